// File: rtl/tdm_demux_pkg.sv
// Shared types and defaults for the TDM demultiplexer.
package tdm_demux_pkg;

  typedef enum logic {
    TDM_HUNT   = 1'b0,
    TDM_LOCKED = 1'b1
  } tdm_state_e;

  localparam int TDM_CH_DEFAULT = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; used for the optional demux statistics.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux.sv
// Receive end of the TDM link: slot tracking, frame reassembly and sync-loss detection.
// Define TDM_DEMUX_STATS_EN to add saturating frame/error counters (frame_cnt, err_cnt).
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int CH     = TDM_CH_DEFAULT,
  parameter int STAT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   din,
  input  logic                   fsync,
  output logic [CH-1:0]          dout,
  output logic                   dout_valid,
  output logic [$clog2(CH)-1:0]  slot,
  output logic                   locked,
  output logic                   sync_err
`ifdef TDM_DEMUX_STATS_EN
  ,
  output logic [STAT_W-1:0]      frame_cnt,
  output logic [STAT_W-1:0]      err_cnt
`endif
);

  localparam int SW = $clog2(CH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(CH - 1);

  if (CH < 2 || CH > 16 || (CH & (CH - 1)) != 0 || STAT_W < 1) begin : g_bad_param
    $error("tdm_demux: CH must be a power of two in 2..16 and STAT_W >= 1");
  end

  tdm_state_e     state_q;
  logic [CH-1:0]  shreg_q;
  logic [CH-1:0]  dout_q;
  logic           dout_valid_q;
  logic [SW-1:0]  slot_q;
  logic           locked_q;
  logic           sync_err_q;
  logic [CH-1:0]  frame_d;

  // The completing word includes the bit arriving in the last slot this cycle.
  always_comb begin
    frame_d         = shreg_q;
    frame_d[CH-1]   = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TDM_HUNT;
      shreg_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      slot_q       <= '0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (en) begin
        unique case (state_q)
          TDM_HUNT: begin
            if (fsync) begin
              shreg_q  <= {{(CH-1){1'b0}}, din};
              slot_q   <= SW'(1);
              state_q  <= TDM_LOCKED;
              locked_q <= 1'b1;
            end
          end
          TDM_LOCKED: begin
            if (fsync) begin
              // A sync anywhere but slot 0 restarts the frame; the partial word is dropped.
              sync_err_q <= (slot_q != '0);
              shreg_q    <= {{(CH-1){1'b0}}, din};
              slot_q     <= SW'(1);
            end else if (slot_q == '0) begin
              sync_err_q <= 1'b1;
              state_q    <= TDM_HUNT;
              locked_q   <= 1'b0;
            end else if (slot_q == LAST_SLOT) begin
              shreg_q[slot_q] <= din;
              dout_q          <= frame_d;
              dout_valid_q    <= 1'b1;
              slot_q          <= '0;
            end else begin
              shreg_q[slot_q] <= din;
              slot_q          <= slot_q + 1'b1;
            end
          end
          default: begin
            state_q  <= TDM_HUNT;
            locked_q <= 1'b0;
            slot_q   <= '0;
          end
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign slot       = slot_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;

`ifdef TDM_DEMUX_STATS_EN
  sat_counter #(.W(STAT_W)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (dout_valid_q),
    .cnt_o (frame_cnt)
  );

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (sync_err_q),
    .cnt_o (err_cnt)
  );
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux (CH=4); statistics checks only when TDM_DEMUX_STATS_EN is defined.
module tb_tdm_demux;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       din;
  logic       fsync;
  logic [3:0] dout;
  logic       dout_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;
`ifdef TDM_DEMUX_STATS_EN
  logic [1:0] frame_cnt;
  logic [1:0] err_cnt;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int errSeen     = 0;
  int expErr      = 0;
  logic [3:0] expQ[$];

  tdm_demux #(.CH(4), .STAT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .fsync      (fsync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
`ifdef TDM_DEMUX_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic d, input logic fs);
    en    = 1'b1;
    din   = d;
    fsync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en    = 1'b0;
    din   = 1'b0;
    fsync = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected word is queued before its first bit so the monitor always finds it.
  task automatic sendFrame(input logic [3:0] w);
    expQ.push_back(w);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(w[k], (k == 0));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sync_err) errSeen++;
      if (dout_valid) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected dout_valid: dout=0x%0h, expected no output", dout);
        end else begin
          checkOutput("dout", dout, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    din   = 1'b0;
    fsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset dout", dout, 0);
    checkOutput("reset dout_valid", dout_valid, 0);
    checkOutput("reset slot", slot, 0);
    checkOutput("reset locked", locked, 0);
    checkOutput("reset sync_err", sync_err, 0);
    rst_n = 1'b1;
    idle(1);

    // First frame after reset
    sendFrame(4'b0110);
    checkOutput("first dout_valid", dout_valid, 1);
    checkOutput("first locked", locked, 1);
    checkOutput("first slot", slot, 0);
    idle(1);
    checkOutput("valid pulse width", dout_valid, 0);
    checkOutput("dout holds", dout, 4'b0110);

    // Back-to-back frames with en held high
    sendFrame(4'b0110);
    sendFrame(4'b1001);
    sendFrame(4'b1111);
    idle(2);
    checkOutput("b2b sync_err count", errSeen, expErr);

    // Gaps between bits
    expQ.push_back(4'b0110);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(k == 1 || k == 2, k == 0);
      idle(2);
      checkOutput("gap slot", slot, (k + 1) % 4);
    end
    checkOutput("gap dout", dout, 4'b0110);

    // Early sync at slot 2 restarts the frame
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    expErr++;
    checkOutput("early sync_err", sync_err, 1);
    checkOutput("early slot", slot, 1);
    checkOutput("early no valid", dout_valid, 0);
    expQ.push_back(4'b1011);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    idle(1);

    // Missing sync at slot 0 drops lock
    applyStimulus(1'b1, 1'b0);
    expErr++;
    checkOutput("missing sync_err", sync_err, 1);
    checkOutput("missing locked", locked, 0);
    checkOutput("missing slot", slot, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("hunt drop locked", locked, 0);
    checkOutput("hunt drop sync_err", sync_err, 0);
    sendFrame(4'b1100);
    idle(1);
    checkOutput("relock locked", locked, 1);
    checkOutput("relock dout", dout, 4'b1100);

    // Asynchronous reset mid-frame
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("pre-reset slot", slot, 3);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async dout", dout, 0);
    checkOutput("async slot", slot, 0);
    checkOutput("async locked", locked, 0);
    checkOutput("async dout_valid", dout_valid, 0);
`ifdef TDM_DEMUX_STATS_EN
    checkOutput("async frame_cnt", frame_cnt, 0);
    checkOutput("async err_cnt", err_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Five frames: counters saturate at 3 with a 2-bit width
    sendFrame(4'b0001);
    sendFrame(4'b0010);
    sendFrame(4'b0100);
    sendFrame(4'b1000);
    sendFrame(4'b0101);
    idle(3);
`ifdef TDM_DEMUX_STATS_EN
    checkOutput("sat frame_cnt", frame_cnt, 3);
    checkOutput("err_cnt after reset", err_cnt, 0);
`endif

    checkOutput("scoreboard drained", expQ.size(), 0);
    checkOutput("sync_err total", errSeen, expErr);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
